// File: rtl/ram_banked.sv
// ram_banked: word-wide RAM made of NUM_BANKS byte-wide synchronous banks,
// one byte lane per bank. A request of 1, 2 or 4 bytes may start at any byte
// address. An access that runs past the end of a row is split into two beats:
// the upper lanes of row r first, then the lower lanes of row r+1. The row
// number wraps, so an access at the top of memory continues at row 0.
//
// Ports:
//   clk_in, rst_in    clock and synchronous active-high reset
//   req_valid_in      request present; accepted when req_ready_out is also high
//   req_ready_out     low during the second beat of a split access and in reset
//   req_wr_in         1 = write, 0 = read
//   req_addr_in       byte address of the lowest byte
//   req_size_in       access is 1<<size bytes, clamped to one full row
//   req_wdata_in      write data; byte i goes to address addr+i
//   rsp_valid_out     one-cycle pulse when read data is presented
//   rsp_rdata_out     read data; byte i = mem[addr+i], unused upper bytes zero;
//                     holds its value between responses
//
// Read data appears READ_LATENCY cycles after the final beat of the read
// (1 = straight from the bank registers, 2 = one more output register).

module single_port_ram_sync #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] dout_r;

    // Storage write and registered read; dout only changes when a read is issued.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= din;
            end else begin
                dout_r <= mem_r[addr];
            end
        end
    end

    assign dout = dout_r;
endmodule

module ram_banked #(
    parameter int ADDR_WIDTH   = 17,
    parameter int NUM_BANKS    = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   req_valid_in,
    output logic                   req_ready_out,
    input  logic                   req_wr_in,
    input  logic [ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [1:0]             req_size_in,
    input  logic [8*NUM_BANKS-1:0] req_wdata_in,
    output logic                   rsp_valid_out,
    output logic [8*NUM_BANKS-1:0] rsp_rdata_out
);
    localparam int OFF   = $clog2(NUM_BANKS);
    localparam int ROW_W = ADDR_WIDTH - OFF;
    localparam int CW    = OFF + 2;          // holds offset + byte count without overflow
    localparam int DW    = 8 * NUM_BANKS;
    localparam logic [CW-1:0] NB_C = CW'(NUM_BANKS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } state_t;

    // Byte count of a request, with sizes wider than a row clamped to one row.
    function automatic logic [CW-1:0] size_bytes(input logic [1:0] size);
        int s;
        s = (int'(size) > OFF) ? OFF : int'(size);
        return CW'(1 << s);
    endfunction

    // Lane/byte index arithmetic modulo NUM_BANKS.
    function automatic logic [OFF-1:0] mod_add(input logic [OFF-1:0] a, input logic [OFF-1:0] b);
        return a + b;
    endfunction

    function automatic logic [OFF-1:0] mod_sub(input logic [OFF-1:0] a, input logic [OFF-1:0] b);
        return a - b;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ROW_W-1:0]  row_r;
    logic [OFF-1:0]    off_r;
    logic [CW-1:0]     n_r;
    logic [DW-1:0]     wdata_r;
    logic              wr_r;

    logic              accept_s;
    logic [ROW_W-1:0]  cur_row_s;
    logic [OFF-1:0]    cur_off_s;
    logic [CW-1:0]     cur_n_s;
    logic              cur_wr_s;
    logic [DW-1:0]     cur_wdata_s;
    logic              go_s;
    logic              beat2_s;
    logic [CW-1:0]     end_s;
    logic              split_s;

    logic              lane_en_s   [NUM_BANKS];
    logic              lane_we_s   [NUM_BANKS];
    logic [7:0]        lane_din_s  [NUM_BANKS];
    logic [7:0]        lane_dout_s [NUM_BANKS];

    // One entry per bank access that was a read, describing how to assemble it.
    logic              p0_valid_r;
    logic              p0_first_r;   // first beat of a split read: goes to staging
    logic              p0_split_r;   // final beat of a split read: merge with staging
    logic [OFF-1:0]    p0_off_r;
    logic [CW-1:0]     p0_n_r;
    logic [DW-1:0]     stage_r;

    logic [DW-1:0]     rot_s;
    logic [DW-1:0]     rd_data_s;
    logic              rd_valid_s;

    assign req_ready_out = (state_r == ST_IDLE) && !rst_in;
    assign accept_s      = req_valid_in && req_ready_out;

    // Select the fields of the beat performed this cycle: live request or latched second beat.
    always_comb begin
        cur_row_s   = req_addr_in[ADDR_WIDTH-1:OFF];
        cur_off_s   = req_addr_in[OFF-1:0];
        cur_n_s     = size_bytes(req_size_in);
        cur_wr_s    = req_wr_in;
        cur_wdata_s = req_wdata_in;
        go_s        = accept_s;
        beat2_s     = 1'b0;
        if (state_r == ST_BEAT2) begin
            cur_row_s   = row_r + ROW_W'(1);
            cur_off_s   = off_r;
            cur_n_s     = n_r;
            cur_wr_s    = wr_r;
            cur_wdata_s = wdata_r;
            go_s        = !rst_in;       // reset cancels a pending second beat
            beat2_s     = 1'b1;
        end else begin
            beat2_s     = 1'b0;
        end
        end_s   = {{(CW-OFF){1'b0}}, cur_off_s} + cur_n_s;
        split_s = (end_s > NB_C);
    end

    // Per-lane enables and write data. Lane l always carries request byte (l - offset) mod NUM_BANKS.
    always_comb begin
        for (int l = 0; l < NUM_BANKS; l++) begin
            lane_en_s[l]  = 1'b0;
            lane_we_s[l]  = 1'b0;
            lane_din_s[l] = cur_wdata_s[8*mod_sub(OFF'(l), cur_off_s) +: 8];
            if (!go_s) begin
                lane_en_s[l] = 1'b0;
            end else if (beat2_s) begin
                lane_en_s[l] = (CW'(l) < (end_s - NB_C));
            end else begin
                lane_en_s[l] = (CW'(l) >= {{(CW-OFF){1'b0}}, cur_off_s}) && (CW'(l) < end_s);
            end
            lane_we_s[l] = lane_en_s[l] && cur_wr_s;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        single_port_ram_sync #(
            .ADDR_WIDTH (ROW_W),
            .DATA_WIDTH (8)
        ) u_bank (
            .clk  (clk_in),
            .en   (lane_en_s[b]),
            .we   (lane_we_s[b]),
            .addr (cur_row_s),
            .din  (lane_din_s[b]),
            .dout (lane_dout_s[b])
        );
    end

    // Next-state logic: a split request spends exactly one extra cycle in BEAT2.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && split_s) begin
                    state_nxt_s = ST_BEAT2;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BEAT2: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the request of a split access so the second beat ignores the live inputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            row_r   <= {ROW_W{1'b0}};
            off_r   <= {OFF{1'b0}};
            n_r     <= {CW{1'b0}};
            wdata_r <= {DW{1'b0}};
            wr_r    <= 1'b0;
        end else if (accept_s && split_s) begin
            row_r   <= req_addr_in[ADDR_WIDTH-1:OFF];
            off_r   <= req_addr_in[OFF-1:0];
            n_r     <= cur_n_s;
            wdata_r <= req_wdata_in;
            wr_r    <= req_wr_in;
        end else begin
            row_r   <= row_r;
            off_r   <= off_r;
            n_r     <= n_r;
            wdata_r <= wdata_r;
            wr_r    <= wr_r;
        end
    end

    // Track read beats alongside the bank read registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            p0_valid_r <= 1'b0;
            p0_first_r <= 1'b0;
            p0_split_r <= 1'b0;
            p0_off_r   <= {OFF{1'b0}};
            p0_n_r     <= {CW{1'b0}};
        end else begin
            p0_valid_r <= go_s && !cur_wr_s;
            p0_first_r <= !beat2_s && split_s;
            p0_split_r <= beat2_s;
            p0_off_r   <= cur_off_s;
            p0_n_r     <= cur_n_s;
        end
    end

    // Rotate bank outputs so the addressed byte lands in byte 0, then mask and merge split halves.
    // Both beats use the same rotation: byte i always comes from lane (offset + i) mod NUM_BANKS.
    always_comb begin
        rot_s     = {DW{1'b0}};
        rd_data_s = {DW{1'b0}};
        for (int i = 0; i < NUM_BANKS; i++) begin
            rot_s[8*i +: 8] = lane_dout_s[mod_add(OFF'(i), p0_off_r)];
            if (CW'(i) >= p0_n_r) begin
                rd_data_s[8*i +: 8] = 8'h00;
            end else if (p0_split_r && (CW'(i) < (NB_C - {{(CW-OFF){1'b0}}, p0_off_r}))) begin
                rd_data_s[8*i +: 8] = stage_r[8*i +: 8];
            end else begin
                rd_data_s[8*i +: 8] = rot_s[8*i +: 8];
            end
        end
        rd_valid_s = p0_valid_r && !p0_first_r;
    end

    // Staging register holding the first-beat bytes of a split read.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stage_r <= {DW{1'b0}};
        end else if (p0_valid_r && p0_first_r) begin
            stage_r <= rot_s;
        end else begin
            stage_r <= stage_r;
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        logic [DW-1:0] hold_r;

        // Remember the last response so the data output is stable between pulses.
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                hold_r <= {DW{1'b0}};
            end else if (rd_valid_s) begin
                hold_r <= rd_data_s;
            end else begin
                hold_r <= hold_r;
            end
        end

        assign rsp_valid_out = rd_valid_s;
        assign rsp_rdata_out = rd_valid_s ? rd_data_s : hold_r;
    end else begin : g_lat2
        logic          rsp_valid_r;
        logic [DW-1:0] rsp_data_r;

        // Extra output register stage; data only loads on a response.
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                rsp_valid_r <= 1'b0;
                rsp_data_r  <= {DW{1'b0}};
            end else if (rd_valid_s) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= rd_data_s;
            end else begin
                rsp_valid_r <= 1'b0;
                rsp_data_r  <= rsp_data_r;
            end
        end

        assign rsp_valid_out = rsp_valid_r;
        assign rsp_rdata_out = rsp_data_r;
    end
endmodule
